// File: rtl/ftps_pkg.sv
// Shared types and constants for the fingertip tracker.
package ftps_pkg;

  // Entry side of the hand; the numeric values are visible on tip_side.
  typedef enum logic [2:0] {
    SIDE_NONE   = 3'd0,
    SIDE_TOP    = 3'd1,
    SIDE_RIGHT  = 3'd2,
    SIDE_BOTTOM = 3'd3,
    SIDE_LEFT   = 3'd4
  } side_t;

  // Frame-processing sequence.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_RESOLVE,
    ST_SMOOTH
  } state_t;

  // Marker colour per side, indexed directly by the side_t value.
  // Unused encodings 5..7 fall back to the NONE colour.
  localparam logic [7:0][15:0] SIDE_COLOR = {
    16'h0ff0, 16'h0ff0, 16'h0ff0,
    16'h000f,   // LEFT
    16'h00f0,   // BOTTOM
    16'h00ff,   // RIGHT
    16'h0f00,   // TOP
    16'h0ff0    // NONE
  };

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ftps_iir.sv
// One axis of first-order IIR smoothing: load copies raw, step moves the
// held value 1/2^SHIFT of the way towards raw, clamped to [0, MAX_VAL].
module ftps_iir #(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned SHIFT   = 2,
  parameter int unsigned MAX_VAL = 319
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] value
);

  logic signed [WIDTH:0] diff;
  logic signed [WIDTH:0] delta;
  logic signed [WIDTH:0] sum;
  logic [WIDTH-1:0]      next_val;

  // Signed step towards raw at width+1, then clamp into the valid range.
  always_comb begin
    diff  = $signed({1'b0, raw}) - $signed({1'b0, value});
    delta = diff >>> SHIFT;
    sum   = $signed({1'b0, value}) + delta;
    if (sum[WIDTH]) begin
      next_val = '0;
    end else if (sum[WIDTH-1:0] > WIDTH'(MAX_VAL)) begin
      next_val = WIDTH'(MAX_VAL);
    end else begin
      next_val = sum[WIDTH-1:0];
    end
  end

  // Held smoothed coordinate.
  always_ff @(posedge pclk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= raw;
    end else if (step) begin
      value <= next_val;
    end
  end

endmodule

// File: rtl/ftps_tracker.sv
// Fingertip tracker: accumulates edge coverage and per-side extremes over a
// binary skin-mask raster, picks the entry side, smooths the tip position
// with hysteresis on loss, and overlays a marker on the display read path.
module ftps_tracker
  import ftps_pkg::*;
#(
  parameter int unsigned X_SIZE       = 320,
  parameter int unsigned Y_SIZE       = 240,
  parameter int unsigned MARGIN       = 20,
  parameter int unsigned EDGE_THRESH  = 20,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned LOST_FRAMES  = 4,
  parameter int unsigned MARK_SIZE    = 10
) (
  input  logic                        pclk,
  input  logic                        reset,
  input  logic                        vsync,
  input  logic                        pix_valid,
  input  logic                        pix_mask,
  output logic [$clog2(X_SIZE)-1:0]   tip_x,
  output logic [$clog2(Y_SIZE)-1:0]   tip_y,
  output side_t                       tip_side,
  output logic                        tip_valid,
  output logic                        tip_lost,
  input  logic [$clog2(X_SIZE)-1:0]   req_x,
  input  logic [$clog2(Y_SIZE)-1:0]   req_y,
  input  logic [15:0]                 req_data,
  output logic [15:0]                 out_data
);

  localparam int unsigned XW = $clog2(X_SIZE);
  localparam int unsigned YW = $clog2(Y_SIZE);
  localparam int unsigned CW = $clog2(max_u(X_SIZE, Y_SIZE) + 1);
  localparam int unsigned MW = $clog2(LOST_FRAMES + 1);

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);
  localparam logic [XW-1:0] X_LO   = XW'(MARGIN);
  localparam logic [XW-1:0] X_HI   = XW'(X_SIZE - 1 - MARGIN);
  localparam logic [YW-1:0] Y_LO   = YW'(MARGIN);
  localparam logic [YW-1:0] Y_HI   = YW'(Y_SIZE - 1 - MARGIN);
  localparam logic [MW-1:0] MISS_MAX = MW'(LOST_FRAMES);

  // Per-side slot index i holds side value i+1, so slots are in priority
  // order: 0=TOP, 1=RIGHT, 2=BOTTOM, 3=LEFT.

  state_t          state;
  logic            vsync_d;
  logic            vs_rise;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            done;
  logic            accept;
  logic            last_pix;

  // One-cycle staging of the accepted pixel keeps the raster counters off
  // the accumulator compare path.
  logic            st_valid;
  logic            st_last;
  logic            st_mask;
  logic [XW-1:0]   st_x;
  logic [YW-1:0]   st_y;
  logic            st_in_box;

  logic [CW-1:0]   cnt   [4];
  logic [XW-1:0]   ext_x [4];
  logic [YW-1:0]   ext_y [4];
  logic [3:0]      ext_found;
  logic [3:0]      on_line;
  logic [3:0]      better;

  side_t           pick_side;
  logic [XW-1:0]   pick_x;
  logic [YW-1:0]   pick_y;
  side_t           res_side;
  logic [XW-1:0]   res_x;
  logic [YW-1:0]   res_y;

  logic [MW-1:0]   miss;
  logic [MW-1:0]   miss_next;
  logic            smooth_go;
  logic            chosen;
  logic            iir_load;
  logic            iir_step;

  // Frame start detection and pixel acceptance; vsync beats a coincident pixel.
  always_comb begin
    vs_rise  = vsync && !vsync_d;
    accept   = (state == ST_ACCUM) && pix_valid && !done && !vs_rise;
    last_pix = accept && (x == X_LAST) && (y == Y_LAST);
  end

  // Line hits and strict "better than stored" tests for the staged pixel.
  always_comb begin
    st_in_box  = (st_x >= X_LO) && (st_x <= X_HI) && (st_y >= Y_LO) && (st_y <= Y_HI);
    on_line[0] = (st_y == Y_LO);
    on_line[1] = (st_x == X_HI);
    on_line[2] = (st_y == Y_HI);
    on_line[3] = (st_x == X_LO);
    better[0]  = !ext_found[0] || (st_y > ext_y[0]);
    better[1]  = !ext_found[1] || (st_x < ext_x[1]);
    better[2]  = !ext_found[2] || (st_y < ext_y[2]);
    better[3]  = !ext_found[3] || (st_x > ext_x[3]);
  end

  // Highest-priority side that is both covered and has a found extreme.
  always_comb begin
    pick_side = SIDE_NONE;
    pick_x    = '0;
    pick_y    = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (ext_found[i-1] && (32'(cnt[i-1]) > EDGE_THRESH)) begin
        pick_side = side_t'(3'(i));
        pick_x    = ext_x[i-1];
        pick_y    = ext_y[i-1];
      end
    end
  end

  // Smoothing control for the publishing cycle.
  always_comb begin
    smooth_go = (state == ST_SMOOTH) && !vs_rise;
    chosen    = (res_side != SIDE_NONE);
    iir_load  = smooth_go && chosen && (tip_lost || (res_side != tip_side));
    iir_step  = smooth_go && chosen && !iir_load;
    miss_next = (miss == MISS_MAX) ? miss : miss + MW'(1);
  end

  // Raster counters, accumulators and the frame FSM with registered outputs.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      vsync_d   <= 1'b0;
      x         <= '0;
      y         <= '0;
      done      <= 1'b0;
      st_valid  <= 1'b0;
      st_last   <= 1'b0;
      st_mask   <= 1'b0;
      st_x      <= '0;
      st_y      <= '0;
      ext_found <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i]   <= '0;
        ext_x[i] <= '0;
        ext_y[i] <= '0;
      end
      res_side  <= SIDE_NONE;
      res_x     <= '0;
      res_y     <= '0;
      tip_side  <= SIDE_NONE;
      tip_valid <= 1'b0;
      tip_lost  <= 1'b1;
      miss      <= '0;
    end else begin
      vsync_d   <= vsync;
      tip_valid <= 1'b0;
      if (vs_rise) begin
        state     <= ST_ACCUM;
        x         <= '0;
        y         <= '0;
        done      <= 1'b0;
        st_valid  <= 1'b0;
        st_last   <= 1'b0;
        ext_found <= '0;
        for (int unsigned i = 0; i < 4; i++) begin
          cnt[i]   <= '0;
          ext_x[i] <= '0;
          ext_y[i] <= '0;
        end
      end else begin
        if (accept) begin
          if (x == X_LAST) begin
            x <= '0;
            if (y != Y_LAST) begin
              y <= y + YW'(1);
            end
          end else begin
            x <= x + XW'(1);
          end
          if (last_pix) begin
            done <= 1'b1;
          end
        end
        st_valid <= accept;
        st_last  <= last_pix;
        st_mask  <= pix_mask;
        st_x     <= x;
        st_y     <= y;

        if (st_valid && st_mask) begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (on_line[i] && (cnt[i] != '1)) begin
              cnt[i] <= cnt[i] + CW'(1);
            end
            if (st_in_box && better[i]) begin
              ext_found[i] <= 1'b1;
              ext_x[i]     <= st_x;
              ext_y[i]     <= st_y;
            end
          end
        end

        case (state)
          ST_ACCUM: begin
            if (st_valid && st_last) begin
              state <= ST_RESOLVE;
            end
          end
          ST_RESOLVE: begin
            res_side <= pick_side;
            res_x    <= pick_x;
            res_y    <= pick_y;
            state    <= ST_SMOOTH;
          end
          ST_SMOOTH: begin
            tip_valid <= 1'b1;
            if (chosen) begin
              tip_side <= res_side;
              miss     <= '0;
              tip_lost <= 1'b0;
            end else begin
              miss <= miss_next;
              if (miss_next == MISS_MAX) begin
                tip_lost <= 1'b1;
              end
            end
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  ftps_iir #(
    .WIDTH  (XW),
    .SHIFT  (SMOOTH_SHIFT),
    .MAX_VAL(X_SIZE - 1)
  ) u_iir_x (
    .pclk (pclk),
    .reset(reset),
    .load (iir_load),
    .step (iir_step),
    .raw  (res_x),
    .value(tip_x)
  );

  ftps_iir #(
    .WIDTH  (YW),
    .SHIFT  (SMOOTH_SHIFT),
    .MAX_VAL(Y_SIZE - 1)
  ) u_iir_y (
    .pclk (pclk),
    .reset(reset),
    .load (iir_load),
    .step (iir_step),
    .raw  (res_y),
    .value(tip_y)
  );

  logic [XW:0] mark_x_end;
  logic [YW:0] mark_y_end;
  logic        in_mark;

  // Marker overlay on the read path; bounds widened by one bit so they never wrap.
  always_comb begin
    mark_x_end = {1'b0, tip_x} + (XW+1)'(MARK_SIZE);
    mark_y_end = {1'b0, tip_y} + (YW+1)'(MARK_SIZE);
    in_mark    = (req_x >= tip_x) && ({1'b0, req_x} < mark_x_end) &&
                 (req_y >= tip_y) && ({1'b0, req_y} < mark_y_end);
    out_data   = (!tip_lost && in_mark) ? SIDE_COLOR[tip_side] : req_data;
  end

endmodule

// File: tb/tb_ftps_tracker.sv
// Scoreboard bench for ftps_tracker on a reduced 40x32 raster.
module tb_ftps_tracker;
  import ftps_pkg::*;

  localparam int XS = 40;
  localparam int YS = 32;
  localparam int MG = 4;
  localparam int TH = 4;
  localparam int SH = 2;
  localparam int LF = 4;
  localparam int MK = 10;
  localparam int XW = $clog2(XS);
  localparam int YW = $clog2(YS);

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_mask = 1'b0;
  logic [XW-1:0] tip_x;
  logic [YW-1:0] tip_y;
  side_t         tip_side;
  logic          tip_valid;
  logic          tip_lost;
  logic [XW-1:0] req_x = '0;
  logic [YW-1:0] req_y = '0;
  logic [15:0]   req_data = '0;
  logic [15:0]   out_data;

  ftps_tracker #(
    .X_SIZE      (XS),
    .Y_SIZE      (YS),
    .MARGIN      (MG),
    .EDGE_THRESH (TH),
    .SMOOTH_SHIFT(SH),
    .LOST_FRAMES (LF),
    .MARK_SIZE   (MK)
  ) dut (
    .pclk     (pclk),
    .reset    (reset),
    .vsync    (vsync),
    .pix_valid(pix_valid),
    .pix_mask (pix_mask),
    .tip_x    (tip_x),
    .tip_y    (tip_y),
    .tip_side (tip_side),
    .tip_valid(tip_valid),
    .tip_lost (tip_lost),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_data (req_data),
    .out_data (out_data)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int side;
    int lost;
    int edge_n;
  } exp_t;

  exp_t sb[$];

  // Reference tracking state.
  int m_x = 0;
  int m_y = 0;
  int m_side = 0;
  int m_lost = 1;
  int m_miss = 0;

  logic [15:0] color_tbl [5] = '{16'h0ff0, 16'h0f00, 16'h00ff, 16'h00f0, 16'h000f};

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Closed-form result for a rectangular mask [x0..x1]x[y0..y1].
  task automatic predict(input int x0, input int x1, input int y0, input int y1, input int edge_n);
    int ct, cb, cl, cr, ix0, ix1, iy0, iy1, side, rx, ry;
    exp_t e;
    bit nonempty;
    nonempty = (x0 <= x1) && (y0 <= y1);
    ct = (nonempty && y0 <= MG && MG <= y1) ? x1 - x0 + 1 : 0;
    cb = (nonempty && y0 <= YS-1-MG && YS-1-MG <= y1) ? x1 - x0 + 1 : 0;
    cl = (nonempty && x0 <= MG && MG <= x1) ? y1 - y0 + 1 : 0;
    cr = (nonempty && x0 <= XS-1-MG && XS-1-MG <= x1) ? y1 - y0 + 1 : 0;
    ix0 = imax(x0, MG); ix1 = imin(x1, XS-1-MG);
    iy0 = imax(y0, MG); iy1 = imin(y1, YS-1-MG);
    side = 0; rx = 0; ry = 0;
    if (nonempty && ix0 <= ix1 && iy0 <= iy1) begin
      if (ct > TH)      begin side = 1; rx = ix0; ry = iy1; end
      else if (cr > TH) begin side = 2; rx = ix0; ry = iy0; end
      else if (cb > TH) begin side = 3; rx = ix0; ry = iy0; end
      else if (cl > TH) begin side = 4; rx = ix1; ry = iy0; end
    end
    if (side != 0) begin
      if (m_lost != 0 || side != m_side) begin
        m_x = rx; m_y = ry;
      end else begin
        m_x = imin(imax(m_x + ((rx - m_x) >>> SH), 0), XS-1);
        m_y = imin(imax(m_y + ((ry - m_y) >>> SH), 0), YS-1);
      end
      m_side = side; m_miss = 0; m_lost = 0;
    end else begin
      if (m_miss < LF) m_miss++;
      if (m_miss == LF) m_lost = 1;
    end
    e.x = m_x; e.y = m_y; e.side = m_side; e.lost = m_lost; e.edge_n = edge_n;
    sb.push_back(e);
  endtask

  // Compare every published result against the scoreboard head.
  logic prev_valid = 1'b0;
  exp_t mon_e;
  always @(negedge pclk) begin
    if (tip_valid) begin
      check("valid_pulse", prev_valid, 0);
      check("result_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("tip_x", tip_x, mon_e.x);
        check("tip_y", tip_y, mon_e.y);
        check("tip_side", tip_side, mon_e.side);
        check("tip_lost", tip_lost, mon_e.lost);
        check("valid_cycle", cyc, mon_e.edge_n);
      end
    end
    prev_valid = tip_valid;
  end

  // Drive one frame; abort_at >= 0 raises vsync together with that pixel.
  task automatic send_frame(input int x0, input int x1, input int y0, input int y1, input int abort_at);
    int idx;
    @(negedge pclk);
    vsync = 1'b1; pix_valid = 1'b0;
    @(negedge pclk);
    vsync = 1'b0;
    idx = 0;
    for (int py = 0; py < YS; py++) begin
      for (int px = 0; px < XS; px++) begin
        while ($urandom_range(0, 7) == 0) begin
          pix_valid = 1'b0;
          pix_mask  = 1'($urandom_range(0, 1));
          @(negedge pclk);
        end
        pix_valid = 1'b1;
        pix_mask  = (px >= x0 && px <= x1 && py >= y0 && py <= y1);
        if (idx == abort_at) begin
          vsync = 1'b1;
          @(negedge pclk);
          vsync = 1'b0; pix_valid = 1'b0; pix_mask = 1'b0;
          return;
        end
        if (idx == XS*YS - 1) predict(x0, x1, y0, y1, cyc + 4);
        @(negedge pclk);
        idx++;
      end
    end
    pix_valid = 1'b1; pix_mask = 1'b1;
    repeat (3) @(negedge pclk);
    pix_valid = 1'b0; pix_mask = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check("result_timeout", sb.size(), 0);
  endtask

  task automatic settle_abort();
    repeat (12) @(negedge pclk);
    check("abort_pending", sb.size(), 0);
  endtask

  task automatic probe(input string tag, input int rx, input int ry);
    logic [15:0] d, want;
    bit hit;
    @(negedge pclk);
    d = 16'($urandom);
    req_x = XW'(rx); req_y = YW'(ry); req_data = d;
    #1;
    hit  = (m_lost == 0) && rx >= m_x && rx < m_x + MK && ry >= m_y && ry < m_y + MK;
    want = hit ? color_tbl[m_side] : d;
    check(tag, out_data, want);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_x"}, tip_x, 0);
    check({pfx, "_y"}, tip_y, 0);
    check({pfx, "_side"}, tip_side, SIDE_NONE);
    check({pfx, "_valid"}, tip_valid, 0);
    check({pfx, "_lost"}, tip_lost, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge pclk);
    check_reset_state("rst");
    reset = 1'b0;
    repeat (2) @(negedge pclk);
    check_reset_state("idle");
    probe("ov_reset", 0, 0);

    send_frame(15, 22, 0, 14, -1); drain();   // top entry
    send_frame(15, 22, 0, 22, -1); drain();   // IIR step
    send_frame(30, 39, 0, 10, -1); drain();   // top beats right, negative step
    send_frame(25, 39, 10, 20, -1); drain();  // right
    send_frame(10, 20, 20, 31, -1); drain();  // bottom
    send_frame(0, 12, 8, 14, -1); drain();    // left
    send_frame(15, 18, 0, 14, -1); drain();   // exactly threshold: not covered
    repeat (3) begin
      send_frame(1, 0, 0, 0, -1); drain();
    end

    probe("ov_lost_a", 12, 8);
    probe("ov_lost_b", 15, 10);
    probe("ov_lost_c", 20, 16);

    send_frame(15, 22, 0, 14, 600); settle_abort();
    send_frame(15, 22, 0, 14, XS*YS - 1); settle_abort();
    send_frame(15, 22, 0, 14, -1); drain();

    probe("ov_hit_origin", 15, 14);
    probe("ov_hit_corner", 24, 23);
    probe("ov_miss_right", 25, 14);
    probe("ov_miss_below", 24, 24);
    probe("ov_miss_left", 14, 14);
    probe("ov_miss_above", 15, 13);

    @(negedge pclk);
    vsync = 1'b1;
    @(negedge pclk);
    vsync = 1'b0; pix_valid = 1'b1; pix_mask = 1'b1;
    repeat (50) @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    check_reset_state("rst_mid");
    reset = 1'b0; pix_valid = 1'b0; pix_mask = 1'b0;
    m_x = 0; m_y = 0; m_side = 0; m_lost = 1; m_miss = 0;
    probe("ov_after_rst", 0, 0);
    repeat (5) @(negedge pclk);
    check("rst_no_valid", tip_valid, 0);

    send_frame(30, 39, 0, 10, -1); drain();
    probe("ov_reacq", 30, 10);

    repeat (5) @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ftps_tracker.md
# ftps_tracker

Parametrised successor to the fixed 320×240 fingertip locator. It consumes the binary skin mask stream from the capture path and derives raster coordinates from pixel counters and `vsync`, so no divider is needed. Per frame it finds the hand's entry side and the fingertip extreme, then applies IIR temporal smoothing and lost-track hysteresis. A marker overlay is drawn on the display read path.

## Interface
Parameters:
- `X_SIZE`, default 320: frame width in pixels.
- `Y_SIZE`, default 240: frame height in lines.
- `MARGIN`, default 20: border width. Edge sensing uses column/row `MARGIN` and `SIZE-1-MARGIN`.
- `EDGE_THRESH`, default 20: a side is covered when its edge count is `> EDGE_THRESH`.
- `SMOOTH_SHIFT`, default 2: IIR gain is 1/2^SMOOTH_SHIFT. A value of 0 disables smoothing.
- `LOST_FRAMES`, default 4: number of consecutive no-cover frames before `tip_lost` asserts.
- `MARK_SIZE`, default 10: overlay marker edge length in pixels.

Ports (`XW=$clog2(X_SIZE)`, `YW=$clog2(Y_SIZE)`):
- `pclk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `vsync` in 1: frame start, in the `pclk` domain. Rising edge starts a frame.
- `pix_valid` in 1: the mask pixel is valid this cycle.
- `pix_mask` in 1: 1 = skin.
- `tip_x` out XW: smoothed tip column.
- `tip_y` out YW: smoothed tip row.
- `tip_side` out 3: entry side, `ftps_pkg::side_t`.
- `tip_valid` out 1: one-cycle pulse when a frame result is published.
- `tip_lost` out 1: tracking lost.
- `req_x` in XW: display read column.
- `req_y` in YW: display read row.
- `req_data` in 16: display pixel.
- `out_data` out 16: `req_data` with the marker overlaid.

## Operation
Raster counters:
- The `vsync` rising edge clears x/y, all accumulators and found flags, and enters state ACCUM.
- Each pixel accepted in ACCUM increments x. x wraps from `X_SIZE-1` to 0 and y increments.
- Pixels are ignored outside ACCUM and after `(X_SIZE-1, Y_SIZE-1)`.

Edge counters:
- Four counters, each `$clog2(max(X_SIZE,Y_SIZE)+1)` bits and saturating.
- Each adds `pix_mask` on its line: top at y==MARGIN, bottom at y==Y_SIZE-1-MARGIN, left at x==MARGIN, right at x==X_SIZE-1-MARGIN.

Extremes:
- Only mask pixels with x in [MARGIN, X_SIZE-1-MARGIN] and y in [MARGIN, Y_SIZE-1-MARGIN] are considered.
- TOP tracks max y; BOTTOM tracks min y; LEFT tracks max x; RIGHT tracks min x.
- Each extreme stores (x,y) with a found flag. Comparison is strict, so the first pixel in raster order wins ties.

FSM: IDLE → (vsync↑) ACCUM → (last pixel accepted) RESOLVE → SMOOTH → IDLE. A `vsync` rising edge in any state forces ACCUM and aborts the current frame; no `tip_valid` is produced for the aborted frame.

RESOLVE:
- A side is chosen only if it is covered and its extreme is found.
- Priority is TOP > RIGHT > BOTTOM > LEFT. If no side qualifies, the result is SIDE_NONE.

SMOOTH, when a side is chosen:
- Load raw directly if `tip_lost` is set or the side differs from the previous `tip_side`.
- Otherwise `s <= s + ((raw - s) >>> SMOOTH_SHIFT)`, computed signed at width+1, with the result within [0, SIZE-1].
- Set the miss counter to 0 and `tip_lost` to 0.

SMOOTH, when the side is SIDE_NONE:
- Hold `tip_x`/`tip_y`/`tip_side`.
- Increment the miss counter, saturating at `LOST_FRAMES`.
- Set `tip_lost` when the counter reaches `LOST_FRAMES`.

Overlay (combinational):
- `out_data = (!tip_lost && req_x in [tip_x, tip_x+MARK_SIZE) && req_y in [tip_y, tip_y+MARK_SIZE)) ? SIDE_COLOR[tip_side] : req_data`.
- Sums are evaluated at width+1, with no wrap.

## Timing
- Reset values: `tip_x=0`, `tip_y=0`, `tip_side=SIDE_NONE`, `tip_valid=0`, `tip_lost=1`, miss counter=0, state IDLE.
- Let edge N be the edge that samples the last pixel. RESOLVE is active in cycle N+1 and SMOOTH in N+2. All `tip_*` outputs update at edge N+3, and `tip_valid` is high only in cycle N+3.
- Accepting the last pixel and receiving `vsync↑` in the same cycle: `vsync` wins and the frame is aborted.
- `reset` mid-frame returns everything to reset values within one edge.
- `out_data` has zero-cycle latency relative to `req_*`.

## Structure
- `ftps_pkg` contains:
  - `side_t`: NONE=0, TOP=1, RIGHT=2, BOTTOM=3, LEFT=4.
  - `SIDE_COLOR`: TOP 16'h0f00, RIGHT 16'h00ff, BOTTOM 16'h00f0, LEFT 16'h000f, NONE 16'h0ff0.
- Sub-module `ftps_iir`, parameterised by width and shift, holding one axis of smoothing with a load/step control. It is instantiated twice, once for x and once for y.

## Test plan
All scenarios use default parameters.
- **Block entering from top:** mask = cols 150–179, rows 0–119. Expect `tip_valid` at N+3, `tip_x=150`, `tip_y=119`, side TOP, `tip_lost=0`.
- **IIR step:** next frame extends the same block to row 127. Expect `tip_y=121` and `tip_x=150`.
- **Priority:** mask covers both row 20 and column 299 with more than 20 pixels each. Expect side TOP.
- **Lost hysteresis:** four empty frames. Expect `tip_lost` to rise only on the 4th `tip_valid`, with `tip_x`/`tip_y` held throughout.
- **Abort:** `vsync↑` mid-frame. Expect no `tip_valid` for that frame; the following full frame gives a correct result.
- **Overlay:**
  - With `tip=(150,119)`: `req=(150,119)` returns 16'h0f00; `req=(160,119)` returns `req_data`.
  - With `tip_lost=1`: every request returns `req_data`.
